multi_irq_ctrl: RTL and testbench

Parametrised successor to the single-source interrupt/reset front end that feeds the 6502C control FSM. It accepts RES, NMI and NUM_IRQ maskable IRQ lines, each synchronised into one clock domain. It arbitrates them by fixed priority and presents one source plus its vector low byte to plaFSM. A take/ack handshake freezes the presented source while the FSM runs the interrupt sequence.

---
 rtl/multi_irq_ctrl_pkg.sv | 30 +++
 rtl/multi_irq_ctrl_if.sv | 39 +++
 rtl/irq_sync_edge.sv | 33 +++
 rtl/multi_irq_ctrl.sv | 159 +++++++++++++++
 tb/tb_multi_irq_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_irq_ctrl_pkg.sv
// Shared encodings for the multi-source interrupt front end: source types,
// fixed vectors, FSM states and the IRQ vector helper.
package multi_irq_ctrl_pkg;

   typedef enum logic [1:0] {
      INT_NONE = 2'b00,
      INT_IRQ  = 2'b01,
      INT_NMI  = 2'b10,
      INT_RES  = 2'b11
   } int_type_e;

   localparam logic [7:0] VEC_RES  = 8'hFC;
   localparam logic [7:0] VEC_NMI  = 8'hFA;
   localparam logic [7:0] VEC_NONE = 8'h00;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_SERVICE = 1'b1;

   typedef struct packed {
      int_type_e  kind;
      logic [2:0] id;
      logic [7:0] vec;
   } int_src_t;

   // Channel k sits two bytes below channel k-1 in the vector table.
   function automatic logic [7:0] irq_vec(input logic [7:0] base, input logic [2:0] idx);
      return base - {4'b0000, idx, 1'b0};
   endfunction

endpackage

// File: rtl/multi_irq_ctrl_if.sv
// Request/handshake bundle between the interrupt front end and plaFSM.
// edgeSel exists only when IRQ_EDGE_EN is defined.
interface multi_irq_ctrl_if #(
   parameter int NUM_IRQ = 4
);
   logic               RES_L;
   logic               NMI_L;
   logic [NUM_IRQ-1:0] IRQ_L;
   logic               flagI;
   logic               enWr;
   logic [NUM_IRQ-1:0] enData;
   logic               intTake;
   logic               intAck;
`ifdef IRQ_EDGE_EN
   logic [NUM_IRQ-1:0] edgeSel;
`endif
   logic               intPending;
   logic [1:0]         intType;
   logic [2:0]         irqId;
   logic [7:0]         vecLo;
   logic               inService;
   logic [NUM_IRQ-1:0] enReg;

   modport master (
`ifdef IRQ_EDGE_EN
      output edgeSel,
`endif
      output RES_L, NMI_L, IRQ_L, flagI, enWr, enData, intTake, intAck,
      input  intPending, intType, irqId, vecLo, inService, enReg
   );

   modport slave (
`ifdef IRQ_EDGE_EN
      input  edgeSel,
`endif
      input  RES_L, NMI_L, IRQ_L, flagI, enWr, enData, intTake, intAck,
      output intPending, intType, irqId, vecLo, inService, enReg
   );
endinterface

// File: rtl/irq_sync_edge.sv
// SYNC_STAGES-deep synchroniser for one active-low async line, plus a pulse
// on each synchronised 1->0 transition. Resets to the inactive (1) level.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic phi2,
   input  logic rstAll,
   input  logic async_i,
   output logic sync_o,
   output logic fall_o
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value.
   always_ff @(posedge phi2) begin
      if (rstAll) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign fall_o = prev_q & ~sync_o;
endmodule

// File: rtl/multi_irq_ctrl.sv
// Fixed-priority RES/NMI/IRQ front end with take/ack freeze for plaFSM.
// Define IRQ_EDGE_EN to add per-channel falling-edge capture via edgeSel.
module multi_irq_ctrl
   import multi_irq_ctrl_pkg::*;
#(
   parameter int         NUM_IRQ      = 4,
   parameter int         SYNC_STAGES  = 2,
   parameter logic [7:0] IRQ_VEC_BASE = 8'hFE
) (
   input logic             phi2,
   input logic             rstAll,
   multi_irq_ctrl_if.slave bus
);
   logic               res_sync, res_fall, nmi_sync, nmi_fall;
   logic [NUM_IRQ-1:0] irq_sync, irq_fall;

   irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_res_sync (
      .phi2(phi2), .rstAll(rstAll), .async_i(bus.RES_L), .sync_o(res_sync), .fall_o(res_fall));
   irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
      .phi2(phi2), .rstAll(rstAll), .async_i(bus.NMI_L), .sync_o(nmi_sync), .fall_o(nmi_fall));

   for (genvar k = 0; k < NUM_IRQ; k++) begin : g_irq_sync
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .phi2(phi2), .rstAll(rstAll), .async_i(bus.IRQ_L[k]),
         .sync_o(irq_sync[k]), .fall_o(irq_fall[k]));
   end

   logic               unused_fall;
`ifdef IRQ_EDGE_EN
   assign unused_fall = res_fall;
`else
   assign unused_fall = res_fall ^ (^irq_fall);
`endif

   logic [0:0]         state_q, state_d;
   int_src_t           frozen_q, frozen_d;
   logic               res_req_q, res_req_d;
   logic               nmi_latch_q, nmi_latch_d;
   logic               nmi_rearm_q, nmi_rearm_d;
   logic [NUM_IRQ-1:0] irq_lvl_q, irq_lvl_d;
   logic [NUM_IRQ-1:0] en_q, en_d;
   logic [NUM_IRQ-1:0] irq_req;
   int_src_t           winner, cur;
   logic               in_service, abort, ack_ok, serve_nmi;

`ifdef IRQ_EDGE_EN
   logic [NUM_IRQ-1:0] edge_q, edge_d;
`endif

   always_comb begin
      irq_req = irq_lvl_q;
`ifdef IRQ_EDGE_EN
      irq_req = (irq_lvl_q & ~bus.edgeSel) |
                (edge_q & bus.edgeSel & en_q & {NUM_IRQ{~bus.flagI}});
`endif
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      winner = '{kind: INT_NONE, id: 3'd0, vec: VEC_NONE};
      if (res_req_q) begin
         winner = '{kind: INT_RES, id: 3'd0, vec: VEC_RES};
      end else if (nmi_latch_q) begin
         winner = '{kind: INT_NMI, id: 3'd0, vec: VEC_NMI};
      end else begin
         // Scan downwards so the lowest requesting channel is written last.
         for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (irq_req[k]) begin
               winner = '{kind: INT_IRQ, id: 3'(k), vec: irq_vec(IRQ_VEC_BASE, 3'(k))};
            end
         end
      end
   end

   // A simultaneous take masks ack; a RES arriving mid-service beats both.
   assign in_service = (state_q == ST_SERVICE);
   assign abort      = in_service & res_req_q & (frozen_q.kind != INT_RES);
   assign ack_ok     = in_service & bus.intAck & ~bus.intTake & ~abort;
   assign serve_nmi  = in_service & (frozen_q.kind == INT_NMI);

   always_comb begin
      state_d  = state_q;
      frozen_d = frozen_q;
      if (state_q == ST_IDLE) begin
         if (bus.intTake && (winner.kind != INT_NONE)) begin
            state_d  = ST_SERVICE;
            frozen_d = winner;
         end
      end else if (abort || ack_ok) begin
         state_d = ST_IDLE;
      end
   end

   always_comb begin
      res_req_d = ~res_sync | (res_req_q & ~(ack_ok & (frozen_q.kind == INT_RES)));

      // One extra NMI edge during its own service is parked in rearm.
      nmi_latch_d = nmi_latch_q | nmi_fall;
      nmi_rearm_d = nmi_rearm_q;
      if (abort) begin
         nmi_rearm_d = 1'b0;
      end else if (serve_nmi) begin
         nmi_latch_d = nmi_latch_q;
         if (ack_ok) begin
            nmi_latch_d = nmi_rearm_q | nmi_fall;
            nmi_rearm_d = 1'b0;
         end else begin
            nmi_rearm_d = nmi_rearm_q | nmi_fall;
         end
      end

      irq_lvl_d = ~irq_sync & en_q & {NUM_IRQ{~bus.flagI}};
      en_d      = bus.enWr ? bus.enData : en_q;
   end

`ifdef IRQ_EDGE_EN
   always_comb begin
      edge_d = edge_q;
      for (int k = 0; k < NUM_IRQ; k++) begin
         edge_d[k] = (irq_fall[k] & bus.edgeSel[k]) |
                     (edge_q[k] & ~(ack_ok & (frozen_q.kind == INT_IRQ) & (frozen_q.id == 3'(k))));
      end
   end
`endif

   always_ff @(posedge phi2) begin
      if (rstAll) begin
         state_q     <= ST_IDLE;
         frozen_q    <= '{kind: INT_NONE, id: 3'd0, vec: VEC_NONE};
         res_req_q   <= 1'b0;
         nmi_latch_q <= 1'b0;
         nmi_rearm_q <= 1'b0;
         irq_lvl_q   <= '0;
         en_q        <= '0;
`ifdef IRQ_EDGE_EN
         edge_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         frozen_q    <= frozen_d;
         res_req_q   <= res_req_d;
         nmi_latch_q <= nmi_latch_d;
         nmi_rearm_q <= nmi_rearm_d;
         irq_lvl_q   <= irq_lvl_d;
         en_q        <= en_d;
`ifdef IRQ_EDGE_EN
         edge_q      <= edge_d;
`endif
      end
   end

   assign cur            = in_service ? frozen_q : winner;
   assign bus.inService  = in_service;
   assign bus.intPending = ~in_service & (winner.kind != INT_NONE);
   assign bus.intType    = cur.kind;
   assign bus.irqId      = cur.id;
   assign bus.vecLo      = cur.vec;
   assign bus.enReg      = en_q;
endmodule

// File: tb/tb_multi_irq_ctrl.sv
// Bench for multi_irq_ctrl: directed handshake scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_multi_irq_ctrl;
   localparam int N = 4;
   localparam int S = 2;

   logic phi2;
   logic rstAll;
   multi_irq_ctrl_if #(.NUM_IRQ(N)) bus ();

   multi_irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S), .IRQ_VEC_BASE(8'hFE)) dut (
      .phi2(phi2), .rstAll(rstAll), .bus(bus));

   initial phi2 = 1'b0;
   always #5 phi2 = ~phi2;

   int checks = 0;
   int errors = 0;
   bit model_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: histories of sampled pins, a pending-NMI count and
   // a served-source record; kinds are 0 none, 1 IRQ, 2 NMI, 3 RES.
   bit [S-1:0] h_res, h_nmi;
   bit [N-1:0] h_irq [S];
   bit         nmi_prev;
   bit         m_res;
   int         m_nmi_pend;
   bit [N-1:0] m_irq, m_en;
   bit         m_serving;
   int         f_kind, f_id;

   function automatic void win(output int kind, output int id);
      kind = 0;
      id   = 0;
      if (m_res) kind = 3;
      else if (m_nmi_pend > 0) kind = 2;
      else begin
         for (int k = N - 1; k >= 0; k--) begin
            if (m_irq[k]) begin
               kind = 1;
               id   = k;
            end
         end
      end
   endfunction

   function automatic int vec_of(input int kind, input int id);
      case (kind)
         3: return 'hFC;
         2: return 'hFA;
         1: return (254 - 2 * id) & 'hFF;
         default: return 0;
      endcase
   endfunction

   task automatic model_step();
      int  wk, wi;
      bit  s_res, s_nmi, fall, take, abort, ack_ok;
      bit  [N-1:0] s_irq;
      if (rstAll) begin
         h_res = '1;
         h_nmi = '1;
         for (int i = 0; i < S; i++) h_irq[i] = '1;
         nmi_prev   = 1'b1;
         m_res      = 1'b0;
         m_nmi_pend = 0;
         m_irq      = '0;
         m_en       = '0;
         m_serving  = 1'b0;
         f_kind     = 0;
         f_id       = 0;
         return;
      end
      s_res  = h_res[S-1];
      s_nmi  = h_nmi[S-1];
      s_irq  = h_irq[S-1];
      fall   = nmi_prev && !s_nmi;
      win(wk, wi);
      take   = bus.intTake;
      abort  = m_serving && m_res && (f_kind != 3);
      ack_ok = m_serving && bus.intAck && !bus.intTake && !abort;

      if (fall) begin
         if (m_serving && f_kind == 2 && !abort) m_nmi_pend = (m_nmi_pend + 1 > 2) ? 2 : m_nmi_pend + 1;
         else if (m_nmi_pend < 1) m_nmi_pend = 1;
      end
      if (abort && m_nmi_pend > 1) m_nmi_pend = 1;
      if (ack_ok && f_kind == 2) m_nmi_pend = m_nmi_pend - 1;

      m_res = !s_res || (m_res && !(ack_ok && f_kind == 3));
      m_irq = ~s_irq & m_en & {N{!bus.flagI}};
      if (bus.enWr) m_en = bus.enData;

      if (!m_serving) begin
         if (take && wk != 0) begin
            m_serving = 1'b1;
            f_kind    = wk;
            f_id      = wi;
         end
      end else if (abort || ack_ok) begin
         m_serving = 1'b0;
      end

      nmi_prev = s_nmi;
      for (int i = S - 1; i > 0; i--) begin
         h_res[i] = h_res[i-1];
         h_nmi[i] = h_nmi[i-1];
         h_irq[i] = h_irq[i-1];
      end
      h_res[0] = bus.RES_L;
      h_nmi[0] = bus.NMI_L;
      h_irq[0] = bus.IRQ_L;
   endtask

   task automatic compare();
      int kind, id;
      if (m_serving) begin
         kind = f_kind;
         id   = f_id;
      end else win(kind, id);
      check("intPending", 32'(bus.intPending), 32'(!m_serving && kind != 0));
      check("inService",  32'(bus.inService),  32'(m_serving));
      check("intType",    32'(bus.intType),    32'(kind));
      check("irqId",      32'(bus.irqId),      32'((kind == 1) ? id : 0));
      check("vecLo",      32'(bus.vecLo),      32'(vec_of(kind, id)));
      check("enReg",      32'(bus.enReg),      32'(m_en));
   endtask

   initial forever begin
      @(posedge phi2);
      model_step();
   end

   initial forever begin
      @(negedge phi2);
      if (model_on) compare();
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge phi2);
         #1;
      end
   endtask

   task automatic take_pulse();
      bus.intTake = 1'b1;
      tick(1);
      bus.intTake = 1'b0;
   endtask

   task automatic ack_pulse();
      bus.intAck = 1'b1;
      tick(1);
      bus.intAck = 1'b0;
   endtask

   task automatic nmi_fall_now();
      bus.NMI_L = 1'b0;
      tick(S + 1);
   endtask

   task automatic write_en(input logic [N-1:0] val);
      bus.enWr   = 1'b1;
      bus.enData = val;
      tick(1);
      bus.enWr   = 1'b0;
   endtask

   initial begin
      int res_cnt;
      rstAll      = 1'b1;
      bus.RES_L   = 1'b1;
      bus.NMI_L   = 1'b1;
      bus.IRQ_L   = '1;
      bus.flagI   = 1'b0;
      bus.enWr    = 1'b0;
      bus.enData  = '0;
      bus.intTake = 1'b0;
      bus.intAck  = 1'b0;
`ifdef IRQ_EDGE_EN
      bus.edgeSel = '0;
`endif
      tick(1);
      rstAll   = 1'b0;
      model_on = 1'b1;
      check("rst_pending", 32'(bus.intPending), 32'd0);
      check("rst_type",    32'(bus.intType),    32'd0);
      check("rst_vec",     32'(bus.vecLo),      32'h00);
      check("rst_enreg",   32'(bus.enReg),      32'h0);
      check("rst_svc",     32'(bus.inService),  32'd0);

      // Fixed priority among IRQs, then global mask via flagI.
      write_en(4'b1111);
      check("en_loaded", 32'(bus.enReg), 32'hF);
      bus.IRQ_L = 4'b1001;
      tick(S);
      check("irq_latency_early", 32'(bus.intPending), 32'd0);
      tick(1);
      check("irq_prio_type", 32'(bus.intType), 32'd1);
      check("irq_prio_id",   32'(bus.irqId),   32'd1);
      check("irq_prio_vec",  32'(bus.vecLo),   32'hFC);
      bus.flagI = 1'b1;
      tick(1);
      check("flagI_mask", 32'(bus.intPending), 32'd0);
      bus.flagI = 1'b0;
      bus.IRQ_L = '1;
      tick(S + 2);

      // NMI beats IRQ2, freezes on take, falls back to IRQ2 on ack.
      bus.IRQ_L = 4'b1011;
      tick(S + 1);
      check("irq2_id",  32'(bus.irqId), 32'd2);
      check("irq2_vec", 32'(bus.vecLo), 32'hFA);
      nmi_fall_now();
      check("nmi_type", 32'(bus.intType), 32'd2);
      check("nmi_vec",  32'(bus.vecLo),   32'hFA);
      take_pulse();
      check("nmi_svc",      32'(bus.inService),  32'd1);
      check("nmi_svc_pend", 32'(bus.intPending), 32'd0);
      bus.NMI_L = 1'b1;
      tick(3);
      check("nmi_frozen", 32'(bus.intType), 32'd2);
      ack_pulse();
      check("back_irq2_svc",  32'(bus.inService), 32'd0);
      check("back_irq2_type", 32'(bus.intType),   32'd1);
      check("back_irq2_id",   32'(bus.irqId),     32'd2);

      // Re-edge during NMI service gives exactly one more service.
      nmi_fall_now();
      take_pulse();
      bus.NMI_L = 1'b1;
      tick(S + 1);
      nmi_fall_now();
      bus.NMI_L = 1'b1;
      tick(S + 1);
      nmi_fall_now();
      check("reedge_still_svc", 32'(bus.inService), 32'd1);
      ack_pulse();
      check("reedge_pend", 32'(bus.intPending), 32'd1);
      check("reedge_type", 32'(bus.intType),    32'd2);
      take_pulse();
      ack_pulse();
      check("no_third_nmi", 32'(bus.intType), 32'd1);
      bus.NMI_L = 1'b1;
      tick(S + 1);

      // RES pre-empts an NMI service; the NMI stays pending.
      nmi_fall_now();
      take_pulse();
      bus.RES_L = 1'b0;
      tick(S + 1);
      check("res_pre_svc", 32'(bus.inService), 32'd1);
      tick(1);
      check("res_abort_svc",  32'(bus.inService), 32'd0);
      check("res_abort_type", 32'(bus.intType),   32'd3);
      check("res_abort_vec",  32'(bus.vecLo),     32'hFC);
      bus.RES_L = 1'b1;
      tick(S + 2);
      check("res_sticky", 32'(bus.intType), 32'd3);
      take_pulse();
      check("res_svc", 32'(bus.inService), 32'd1);
      ack_pulse();
      check("nmi_kept_type", 32'(bus.intType), 32'd2);
      check("nmi_kept_vec",  32'(bus.vecLo),   32'hFA);
      take_pulse();
      ack_pulse();
      check("after_res_irq2", 32'(bus.intType), 32'd1);

      // Enable write racing the first request cycle costs one cycle.
      bus.IRQ_L = '1;
      write_en('0);
      tick(S + 2);
      check("race_idle", 32'(bus.intPending), 32'd0);
      write_en(4'b0001);
      bus.IRQ_L = 4'b1110;
      tick(S + 1);
      check("preset_seen", 32'(bus.intPending), 32'd1);
      check("preset_vec",  32'(bus.vecLo),      32'hFE);
      bus.IRQ_L = '1;
      write_en('0);
      tick(S + 2);
      bus.IRQ_L = 4'b1110;
      tick(S);
      write_en(4'b0001);
      check("race_late", 32'(bus.intPending), 32'd0);
      tick(1);
      check("race_seen", 32'(bus.intPending), 32'd1);
      check("race_id",   32'(bus.irqId),      32'd0);

      // Randomized traffic against the model.
      res_cnt = 0;
      for (int c = 0; c < 4000; c++) begin
         rstAll = ($urandom_range(0, 799) == 0);
         if (res_cnt > 0) res_cnt--;
         else if ($urandom_range(0, 199) == 0) res_cnt = $urandom_range(1, 6);
         bus.RES_L = (res_cnt == 0);
         if ($urandom_range(0, 7) == 0) bus.NMI_L = ~bus.NMI_L;
         if ($urandom_range(0, 5) == 0) bus.IRQ_L = N'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) bus.flagI = ~bus.flagI;
         bus.enWr    = ($urandom_range(0, 15) == 0);
         bus.enData  = N'($urandom_range(0, 15));
         bus.intTake = ($urandom_range(0, 4) == 0);
         bus.intAck  = ($urandom_range(0, 4) == 0);
         tick(1);
      end
      rstAll      = 1'b0;
      bus.enWr    = 1'b0;
      bus.intTake = 1'b0;
      bus.intAck  = 1'b0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
